// File: rtl/bpred_resolve_pkg.sv
// Shared types for branch-prediction resolution: FSM states, the prediction
// queue entry, update-payload field offsets and the 2-bit counter update.
package bpred_resolve_pkg;

   localparam int QDEPTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UPD  = 2'd1,
      RAS  = 2'd2
   } state_t;

   // Payload layout: update carries {2'b00, new_ctr, bim_idx}; recovery carries {12'h000, ras_idx}
   localparam int META_IDX_LSB = 0;
   localparam int META_CTR_LSB = 12;
   localparam int META_RAS_LSB = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pred_pc;
      logic        p_dir;
      logic [11:0] bim_idx;
      logic [1:0]  bim_ctr;
      logic [3:0]  ras_idx;
      logic        is_callret;
   } pq_entry_t;

   function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
      if (taken) return (ctr == 2'd3) ? ctr : ctr + 2'd1;
      else       return (ctr == 2'd0) ? ctr : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/bpred_pqueue.sv
// In-order prediction queue: one push and one pop per cycle, flush empties it
// and discards a same-cycle push.
module bpred_pqueue
   import bpred_resolve_pkg::*;
#(
   parameter int DEPTH = QDEPTH_DEF
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push,
   input  pq_entry_t wdata,
   input  logic      pop,
   input  logic      flush,
   output pq_entry_t head,
   output logic      full,
   output logic      empty,
   output logic      ovf
);

   localparam int AW = $clog2(DEPTH);

   pq_entry_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            do_pop;
   logic            do_push;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full queue still accepts the push
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push && !do_push) ovf <= 1'b1;
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bpred_resolve.sv
// Compares resolved branches against queued predictions, drives predictor
// updates, fetch redirects and RAS recovery.
module bpred_resolve
   import bpred_resolve_pkg::*;
#(
   parameter int QDEPTH = QDEPTH_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fq_push,
   input  logic [31:0] fq_pc,
   input  logic [31:0] fq_pred_pc,
   input  logic        fq_p_dir,
   input  logic [11:0] fq_bim_idx,
   input  logic [1:0]  fq_bim_ctr,
   input  logic [3:0]  fq_ras_idx,
   input  logic        fq_is_callret,
   output logic        fq_full,
   output logic        fq_ovf,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic        ex_dir,
   input  logic [31:0] ex_target,
   input  logic        soin_bpredictor_stall,
   output logic        fetch_redirect,
   output logic [31:0] fetch_redirect_PC,
   output logic        execute_bpredictor_update,
   output logic [31:0] execute_bpredictor_PC4,
   output logic [31:0] execute_bpredictor_target,
   output logic        execute_bpredictor_dir,
   output logic        execute_bpredictor_miss,
   output logic        execute_bpredictor_recover_ras,
   output logic [15:0] execute_bpredictor_meta
);

   state_t      state;
   logic        rec_pend;
   logic [3:0]  ras_idx_q;
   pq_entry_t   wentry;
   pq_entry_t   head;
   logic        q_empty;
   logic        accept;
   logic [31:0] pc4;
   logic [31:0] actual;
   logic        miss;
   logic [1:0]  new_ctr;
   logic [15:0] upd_meta;
   logic [15:0] ras_meta;

   assign wentry = '{pc: fq_pc, pred_pc: fq_pred_pc, p_dir: fq_p_dir, bim_idx: fq_bim_idx,
                     bim_ctr: fq_bim_ctr, ras_idx: fq_ras_idx, is_callret: fq_is_callret};

   bpred_pqueue #(.DEPTH(QDEPTH)) u_pqueue (
      .clk   (clk),
      .reset (reset),
      .push  (fq_push),
      .wdata (wentry),
      .pop   (accept),
      .flush (accept & miss),
      .head  (head),
      .full  (fq_full),
      .empty (q_empty),
      .ovf   (fq_ovf)
   );

   assign ex_ready = ~q_empty & ~soin_bpredictor_stall &
                     ((state == IDLE) | ((state == UPD) & ~rec_pend));
   assign accept   = ex_valid & ex_ready;
   assign pc4      = head.pc + 32'd4;
   assign actual   = ex_dir ? ex_target : pc4;
   assign miss     = (actual != head.pred_pc);
   assign new_ctr  = sat_ctr(head.bim_ctr, ex_dir);
   assign upd_meta = (16'(new_ctr) << META_CTR_LSB) | (16'(head.bim_idx) << META_IDX_LSB);
   assign ras_meta = 16'(ras_idx_q) << META_RAS_LSB;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                          <= IDLE;
         rec_pend                       <= 1'b0;
         ras_idx_q                      <= '0;
         fetch_redirect                 <= 1'b0;
         fetch_redirect_PC              <= '0;
         execute_bpredictor_update      <= 1'b0;
         execute_bpredictor_PC4         <= '0;
         execute_bpredictor_target      <= '0;
         execute_bpredictor_dir         <= 1'b0;
         execute_bpredictor_miss        <= 1'b0;
         execute_bpredictor_recover_ras <= 1'b0;
         execute_bpredictor_meta        <= '0;
      end else begin
         // Redirect is a pulse; a stall holds everything else but never re-fires it
         fetch_redirect <= 1'b0;
         if (accept) begin
            state                          <= UPD;
            rec_pend                       <= miss & head.is_callret;
            ras_idx_q                      <= head.ras_idx;
            fetch_redirect                 <= miss;
            fetch_redirect_PC              <= actual;
            execute_bpredictor_update      <= 1'b1;
            execute_bpredictor_PC4         <= pc4;
            execute_bpredictor_target      <= ex_target;
            execute_bpredictor_dir         <= ex_dir;
            execute_bpredictor_miss        <= miss;
            execute_bpredictor_recover_ras <= 1'b0;
            execute_bpredictor_meta        <= upd_meta;
         end else if (!soin_bpredictor_stall) begin
            case (state)
               UPD: begin
                  execute_bpredictor_update <= 1'b0;
                  if (rec_pend) begin
                     state                          <= RAS;
                     rec_pend                       <= 1'b0;
                     execute_bpredictor_recover_ras <= 1'b1;
                     execute_bpredictor_meta        <= ras_meta;
                  end else begin
                     state                   <= IDLE;
                     execute_bpredictor_miss <= 1'b0;
                  end
               end
               RAS: begin
                  state                          <= IDLE;
                  execute_bpredictor_recover_ras <= 1'b0;
                  execute_bpredictor_miss        <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bpred_resolve.sv
// Directed checks of prediction resolution: hits, misses, RAS recovery,
// queue full/overflow, stall hold and mid-operation reset.
module tb_bpred_resolve;

   logic        clk = 1'b0;
   logic        reset;
   logic        fq_push;
   logic [31:0] fq_pc;
   logic [31:0] fq_pred_pc;
   logic        fq_p_dir;
   logic [11:0] fq_bim_idx;
   logic [1:0]  fq_bim_ctr;
   logic [3:0]  fq_ras_idx;
   logic        fq_is_callret;
   logic        fq_full;
   logic        fq_ovf;
   logic        ex_valid;
   logic        ex_ready;
   logic        ex_dir;
   logic [31:0] ex_target;
   logic        stall;
   logic        redir;
   logic [31:0] redir_pc;
   logic        upd;
   logic [31:0] pc4;
   logic [31:0] tgt;
   logic        dir;
   logic        miss;
   logic        rec;
   logic [15:0] meta;

   int total = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bpred_resolve #(.QDEPTH(8)) dut (
      .clk                            (clk),
      .reset                          (reset),
      .fq_push                        (fq_push),
      .fq_pc                          (fq_pc),
      .fq_pred_pc                     (fq_pred_pc),
      .fq_p_dir                       (fq_p_dir),
      .fq_bim_idx                     (fq_bim_idx),
      .fq_bim_ctr                     (fq_bim_ctr),
      .fq_ras_idx                     (fq_ras_idx),
      .fq_is_callret                  (fq_is_callret),
      .fq_full                        (fq_full),
      .fq_ovf                         (fq_ovf),
      .ex_valid                       (ex_valid),
      .ex_ready                       (ex_ready),
      .ex_dir                         (ex_dir),
      .ex_target                      (ex_target),
      .soin_bpredictor_stall          (stall),
      .fetch_redirect                 (redir),
      .fetch_redirect_PC              (redir_pc),
      .execute_bpredictor_update      (upd),
      .execute_bpredictor_PC4         (pc4),
      .execute_bpredictor_target      (tgt),
      .execute_bpredictor_dir         (dir),
      .execute_bpredictor_miss        (miss),
      .execute_bpredictor_recover_ras (rec),
      .execute_bpredictor_meta        (meta)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_entry(input logic [31:0] pc, input logic [31:0] pp, input logic [11:0] idx,
                            input logic [1:0] ctr, input logic [3:0] ras, input logic cr);
      fq_pc = pc; fq_pred_pc = pp; fq_p_dir = 1'b0; fq_bim_idx = idx;
      fq_bim_ctr = ctr; fq_ras_idx = ras; fq_is_callret = cr;
   endtask

   task automatic push1(input logic [31:0] pc, input logic [31:0] pp, input logic [11:0] idx,
                        input logic [1:0] ctr, input logic [3:0] ras, input logic cr);
      set_entry(pc, pp, idx, ctr, ras, cr);
      fq_push = 1'b1;
      tick();
      fq_push = 1'b0;
   endtask

   task automatic resolve(input logic d, input logic [31:0] t);
      ex_valid = 1'b1; ex_dir = d; ex_target = t;
      tick();
      ex_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0; fq_push = 1'b0; ex_valid = 1'b0; ex_dir = 1'b0; ex_target = '0; stall = 1'b0;
      set_entry(32'h0, 32'h0, 12'h0, 2'd0, 4'd0, 1'b0);
      tick(); tick();
      chk("rst_update", upd, 0);
      chk("rst_redirect", redir, 0);
      chk("rst_full", fq_full, 0);
      chk("rst_ovf", fq_ovf, 0);
      chk("rst_ex_ready", ex_ready, 0);
      chk("rst_meta", meta, 0);
      reset = 1'b1;
      tick();

      // Correct not-taken prediction
      push1(32'h100, 32'h104, 12'h0AB, 2'd1, 4'd0, 1'b0);
      chk("hit_ex_ready", ex_ready, 1);
      resolve(1'b0, 32'h999);
      chk("hit_update", upd, 1);
      chk("hit_miss", miss, 0);
      chk("hit_pc4", pc4, 32'h104);
      chk("hit_meta", meta, 16'h00AB);
      chk("hit_target", tgt, 32'h999);
      chk("hit_redirect", redir, 0);
      tick();
      chk("hit_idle_update", upd, 0);
      chk("hit_empty", ex_ready, 0);

      // Taken miss with a wrong-path push at the flush edge
      push1(32'h200, 32'h204, 12'h123, 2'd3, 4'd0, 1'b0);
      set_entry(32'h300, 32'h304, 12'h0, 2'd0, 4'd0, 1'b0);
      fq_push = 1'b1;
      resolve(1'b1, 32'h400);
      fq_push = 1'b0;
      chk("miss_redirect", redir, 1);
      chk("miss_redirect_pc", redir_pc, 32'h400);
      chk("miss_miss", miss, 1);
      chk("miss_dir", dir, 1);
      chk("miss_meta", meta, 16'h3123);
      chk("miss_flushed", ex_ready, 0);
      tick();
      chk("miss_redirect_pulse", redir, 0);
      chk("miss_still_empty", ex_ready, 0);

      // Mispredicted return: update then RAS recovery
      push1(32'h500, 32'h504, 12'h010, 2'd2, 4'd5, 1'b1);
      resolve(1'b1, 32'h800);
      chk("ras_n1_update", upd, 1);
      chk("ras_n1_recover", rec, 0);
      chk("ras_n1_meta", meta, 16'h3010);
      chk("ras_n1_ex_ready", ex_ready, 0);
      tick();
      chk("ras_n2_recover", rec, 1);
      chk("ras_n2_update", upd, 0);
      chk("ras_n2_meta", meta, 16'h0005);
      tick();
      chk("ras_n3_recover", rec, 0);

      // Fill, overflow, push+pop on full, then drain in order
      for (int i = 0; i < 8; i++)
         push1(32'h1000 + 32'(16 * i), 32'h1004 + 32'(16 * i), 12'(i), 2'd0, 4'd0, 1'b0);
      chk("fill_full", fq_full, 1);
      chk("fill_no_ovf", fq_ovf, 0);
      push1(32'h9000, 32'h9004, 12'h0, 2'd0, 4'd0, 1'b0);
      chk("ovf_set", fq_ovf, 1);
      chk("ovf_full", fq_full, 1);
      set_entry(32'h2000, 32'h2004, 12'h0, 2'd0, 4'd0, 1'b0);
      fq_push = 1'b1;
      resolve(1'b0, 32'h0);
      fq_push = 1'b0;
      chk("pushpop_full", fq_full, 1);
      chk("pushpop_pc4", pc4, 32'h1004);
      ex_valid = 1'b1; ex_dir = 1'b0;
      for (int i = 1; i < 8; i++) begin
         tick();
         chk($sformatf("drain_pc4_%0d", i), pc4, 32'h1004 + 32'(16 * i));
      end
      tick();
      chk("drain_last_pc4", pc4, 32'h2004);
      chk("drain_last_miss", miss, 0);
      ex_valid = 1'b0;
      tick();
      chk("drain_idle", upd, 0);
      chk("drain_empty", ex_ready, 0);
      chk("drain_not_full", fq_full, 0);
      chk("ovf_sticky", fq_ovf, 1);

      // Stall held across UPD for three edges
      push1(32'h600, 32'h604, 12'h055, 2'd1, 4'd0, 1'b0);
      resolve(1'b1, 32'hA00);
      stall = 1'b1;
      set_entry(32'h700, 32'h704, 12'h0, 2'd0, 4'd0, 1'b0);
      fq_push = 1'b1;
      chk("stall_n1_redirect", redir, 1);
      chk("stall_n1_redirect_pc", redir_pc, 32'hA00);
      tick();
      fq_push = 1'b0;
      chk("stall_n2_update", upd, 1);
      chk("stall_n2_redirect", redir, 0);
      chk("stall_n2_meta", meta, 16'h2055);
      chk("stall_n2_pc4", pc4, 32'h604);
      chk("stall_n2_ex_ready", ex_ready, 0);
      tick();
      chk("stall_n3_update", upd, 1);
      chk("stall_n3_redirect", redir, 0);
      tick();
      chk("stall_n4_update", upd, 1);
      chk("stall_n4_miss", miss, 1);
      stall = 1'b0;
      #1;
      chk("stall_release_ready", ex_ready, 1);
      tick();
      chk("stall_advanced", upd, 0);

      // Reset while in RAS with four queued entries
      resolve(1'b0, 32'h0);
      tick();
      push1(32'hB00, 32'hB04, 12'h007, 2'd0, 4'd9, 1'b1);
      set_entry(32'hD00, 32'hD04, 12'h0, 2'd0, 4'd0, 1'b0);
      fq_push = 1'b1;
      resolve(1'b1, 32'hC00);
      tick();
      stall = 1'b1;
      tick(); tick(); tick();
      fq_push = 1'b0;
      chk("mid_in_ras", rec, 1);
      chk("mid_ras_meta", meta, 16'h0009);
      reset = 1'b0;
      #1;
      chk("mid_rst_recover", rec, 0);
      chk("mid_rst_update", upd, 0);
      chk("mid_rst_meta", meta, 0);
      chk("mid_rst_redirect_pc", redir_pc, 0);
      chk("mid_rst_pc4", pc4, 0);
      chk("mid_rst_ovf", fq_ovf, 0);
      chk("mid_rst_full", fq_full, 0);
      chk("mid_rst_ex_ready", ex_ready, 0);
      stall = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("post_rst_empty", ex_ready, 0);
      chk("post_rst_update", upd, 0);
      chk("post_rst_recover", rec, 0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
